// File: rtl/fetch_pkg.sv
// Shared types and default geometry for the column fetch path.
package fetch_pkg;

    localparam int unsigned DEF_DATA_WIDTH      = 24;
    localparam int unsigned DEF_ADDRESS_WIDTH   = 11;
    localparam int unsigned DEF_NUM_COLUMNS     = 64;
    localparam int unsigned DEF_LEDS_PER_COLUMN = 32;

    localparam int unsigned COL_W = $clog2(DEF_NUM_COLUMNS);
    localparam int unsigned LED_W = $clog2(DEF_LEDS_PER_COLUMN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pix_skid_buf.sv
// Two-entry FIFO holding returned ROM words (data + last tag) ahead of the LED driver.
module pix_skid_buf #(
    parameter int unsigned WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_pop;

    assign do_pop = pop_i && (count_q != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_i) - 2'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/column_fetch.sv
// Streams one column of pixel words from a 1-cycle-latency ROM to the LED driver,
// issuing reads only when the 2-entry buffer is guaranteed room for the return.
module column_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH   = DEF_ADDRESS_WIDTH,
    parameter int unsigned NUM_COLUMNS     = DEF_NUM_COLUMNS,
    parameter int unsigned LEDS_PER_COLUMN = DEF_LEDS_PER_COLUMN
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [$clog2(NUM_COLUMNS)-1:0] column,
    output logic                           busy,
    output logic                           done,
    output logic [ADDRESS_WIDTH-1:0]       rom_addr,
    input  logic [DATA_WIDTH-1:0]          rom_data,
    output logic [DATA_WIDTH-1:0]          pix_data,
    output logic                           pix_valid,
    output logic                           pix_last,
    input  logic                           pix_ready
);

    localparam int unsigned CW = $clog2(NUM_COLUMNS);
    localparam int unsigned IW = $clog2(LEDS_PER_COLUMN + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(LEDS_PER_COLUMN - 1);
    localparam logic [IW-1:0] END_IDX  = IW'(LEDS_PER_COLUMN);

    fetch_state_e             state_q;
    logic [ADDRESS_WIDTH-1:0] base_q;
    logic [ADDRESS_WIDTH-1:0] rom_addr_q;
    logic [IW-1:0]            led_idx_q;
    logic                     addr_vld_q;
    logic                     addr_last_q;
    logic                     inflight_q;
    logic                     inflight_last_q;
    logic                     busy_q;
    logic                     done_q;

    logic                     col_ok;
    logic                     pop;
    logic                     issue;
    logic                     load;
    logic [1:0]               count;
    logic [2:0]               credit;
    logic [DATA_WIDTH:0]      head;
    logic                     head_valid;

    // Out-of-range columns only exist when NUM_COLUMNS is not a power of two.
    if ((32'd1 << CW) == NUM_COLUMNS) begin : g_col_pow2
        assign col_ok = 1'b1;
    end else begin : g_col_npow2
        assign col_ok = (32'(column) < NUM_COLUMNS);
    end

    // rom_addr_q holds the next address; it is a real read only on the cycle it is issued.
    assign pop    = head_valid && pix_ready;
    assign credit = 3'(count) + 3'(inflight_q) - 3'(pop);
    assign issue  = (state_q == ST_FETCH) && addr_vld_q && (credit < 3'd2);
    assign load   = (state_q == ST_FETCH) && (led_idx_q != END_IDX) && (!addr_vld_q || issue);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            base_q          <= '0;
            rom_addr_q      <= '0;
            led_idx_q       <= '0;
            addr_vld_q      <= 1'b0;
            addr_last_q     <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= issue;
            inflight_last_q <= issue && addr_last_q;
            if (load) begin
                rom_addr_q  <= base_q + ADDRESS_WIDTH'(led_idx_q);
                addr_last_q <= (led_idx_q == LAST_IDX);
                led_idx_q   <= led_idx_q + IW'(1);
                addr_vld_q  <= 1'b1;
            end else if (issue) begin
                addr_vld_q  <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start && col_ok) begin
                        state_q   <= ST_FETCH;
                        base_q    <= ADDRESS_WIDTH'(column) * ADDRESS_WIDTH'(LEDS_PER_COLUMN);
                        led_idx_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (issue && addr_last_q) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && head[DATA_WIDTH]) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    pix_skid_buf #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_buf (
        .clk         (clk),
        .rst         (reset),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, rom_data}),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (head_valid),
        .count_o     (count)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign rom_addr  = rom_addr_q;
    assign pix_data  = head[DATA_WIDTH-1:0];
    assign pix_valid = head_valid;
    assign pix_last  = head_valid && head[DATA_WIDTH];

endmodule

// File: tb/tb_column_fetch.sv
// Directed + randomized bench for column_fetch against a behavioural ROM/stream model.
`timescale 1ns/1ps
module tb_column_fetch;
    import fetch_pkg::*;

    localparam int unsigned DW  = 24;
    localparam int unsigned AW  = 11;
    localparam int unsigned NC  = 64;
    localparam int unsigned LPC = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [COL_W-1:0] column;
    logic             busy;
    logic             done;
    logic [AW-1:0]    rom_addr;
    logic [DW-1:0]    rom_data;
    logic [DW-1:0]    pix_data;
    logic             pix_valid;
    logic             pix_last;
    logic             pix_ready;

    logic [DW-1:0]    rom [2048];
    logic [DW:0]      exp_q [$];
    logic [DW:0]      exp_w;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int last_cnt = 0;
    int done_cnt = 0;

    column_fetch #(
        .DATA_WIDTH      (DW),
        .ADDRESS_WIDTH   (AW),
        .NUM_COLUMNS     (NC),
        .LEDS_PER_COLUMN (LPC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .column    (column),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_last  (pix_last),
        .pix_ready (pix_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Stream monitor: every handshake must match the next expected {last, word}.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            checks++;
            assert (!(dut.u_buf.push_i && !dut.u_buf.pop_i && dut.u_buf.count_o == 2'd2))
            else begin
                errors++;
                $error("FAIL overflow cyc=%0d count=%0d", cyc, dut.u_buf.count_o);
            end
            if (pix_valid && pix_ready) begin
                hs_cnt++;
                if (pix_last) last_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL pix_extra got=%h want=none", {pix_last, pix_data});
                end else begin
                    exp_w = exp_q.pop_front();
                    assert ({pix_last, pix_data} === exp_w)
                    else begin
                        errors++;
                        $error("FAIL pix_word got=%h want=%h", {pix_last, pix_data}, exp_w);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic expect_col(input int col);
        for (int i = 0; i < LPC; i++) begin
            exp_q.push_back({(i == LPC - 1), rom[col * LPC + i]});
        end
    endtask

    // Drives start for one cycle; n returns the cycle number of the sampling edge.
    task automatic start_col(input int col, output int n);
        @(posedge clk);
        #1;
        start  = 1'b1;
        column = COL_W'(col);
        @(posedge clk);
        #1;
        start  = 1'b0;
        n      = cyc;
    endtask

    task automatic wait_done(input string tag, input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            errors++;
            $error("FAIL %s_timeout got=no_done want=done", tag);
        end
    endtask

    initial begin
        int n, m, at, h0, l0, d0;
        logic [DW-1:0] head;
        logic [31:0]   r;
        bit            got;

        for (int i = 0; i < 2048; i++) begin
            r      = $urandom;
            rom[i] = {r[12:0], 11'(i)};
        end
        reset     = 1'b1;
        start     = 1'b0;
        column    = '0;
        pix_ready = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_valid", 32'(pix_valid), 0);
        chk("rst_last", 32'(pix_last), 0);
        chk("rst_data", 32'(pix_data), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1: column 3 with ready held high
        h0 = hs_cnt; l0 = last_cnt; d0 = done_cnt;
        expect_col(3);
        start_col(3, n);
        chk("t1_busy", 32'(busy), 1);
        @(negedge clk);
        for (int i = 0; i < LPC; i++) begin
            @(negedge clk);
            chk("t1_addr", 32'(rom_addr), 32'(3 * LPC + i));
        end
        wait_done("t1_done", 50, at);
        chk("t1_done_cyc", 32'(at), 32'(n + 35));
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_busy_end", 32'(busy), 0);
        #1;
        chk("t1_hs", 32'(hs_cnt - h0), LPC);
        chk("t1_last", 32'(last_cnt - l0), 1);
        chk("t1_dones", 32'(done_cnt - d0), 1);
        chk("t1_q", 32'(exp_q.size()), 0);

        // 2: stall 10 cycles on the first pixel
        pix_ready = 1'b0;
        h0 = hs_cnt;
        expect_col(7);
        start_col(7, n);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (pix_valid) got = 1'b1;
        end
        chk("t2_valid", 32'(got), 1);
        head = pix_data;
        chk("t2_head", 32'(head), 32'(rom[7 * LPC]));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_hold", 32'(pix_data), 32'(head));
            chk("t2_addr_lim", 32'(rom_addr <= AW'(7 * LPC + 2)), 1);
        end
        @(posedge clk);
        #1 pix_ready = 1'b1;
        wait_done("t2_done", 100, at);
        #1;
        chk("t2_hs", 32'(hs_cnt - h0), LPC);
        chk("t2_q", 32'(exp_q.size()), 0);

        // 3: random ready over column 63
        h0 = hs_cnt; l0 = last_cnt; d0 = done_cnt;
        expect_col(63);
        start_col(63, n);
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(posedge clk);
            #1 pix_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) got = 1'b1;
        end
        pix_ready = 1'b1;
        chk("t3_done", 32'(got), 1);
        repeat (3) @(negedge clk);
        #1;
        chk("t3_hs", 32'(hs_cnt - h0), LPC);
        chk("t3_last", 32'(last_cnt - l0), 1);
        chk("t3_dones", 32'(done_cnt - d0), 1);
        chk("t3_q", 32'(exp_q.size()), 0);

        // 4: second start mid-column is ignored
        h0 = hs_cnt; d0 = done_cnt;
        expect_col(2);
        start_col(2, n);
        repeat (3) @(posedge clk);
        start_col(5, m);
        wait_done("t4_done", 100, at);
        repeat (10) @(negedge clk);
        #1;
        chk("t4_busy", 32'(busy), 0);
        chk("t4_valid", 32'(pix_valid), 0);
        chk("t4_hs", 32'(hs_cnt - h0), LPC);
        chk("t4_dones", 32'(done_cnt - d0), 1);
        chk("t4_q", 32'(exp_q.size()), 0);

        // 5: asynchronous reset after 10 pixels of column 1
        h0 = hs_cnt;
        expect_col(1);
        start_col(1, n);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            #1;
            if (hs_cnt - h0 >= 10) got = 1'b1;
        end
        chk("t5_ten", 32'(got), 1);
        #1 reset = 1'b1;
        #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_addr", 32'(rom_addr), 0);
        chk("t5_valid", 32'(pix_valid), 0);
        chk("t5_last", 32'(pix_last), 0);
        chk("t5_data", 32'(pix_data), 0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("t5_nodone", 32'(done_cnt - d0), 0);
        chk("t5_idle", 32'(busy), 0);
        h0 = hs_cnt;
        expect_col(0);
        start_col(0, n);
        wait_done("t5_done0", 100, at);
        chk("t5_done0_cyc", 32'(at), 32'(n + 35));
        #1;
        chk("t5_hs0", 32'(hs_cnt - h0), LPC);
        chk("t5_q", 32'(exp_q.size()), 0);

        // 6: start accepted in the done cycle
        h0 = hs_cnt; d0 = done_cnt;
        expect_col(10);
        start_col(10, n);
        wait_done("t6_done_a", 100, at);
        start  = 1'b1;
        column = COL_W'(11);
        expect_col(11);
        @(posedge clk);
        #1 start = 1'b0;
        m = cyc;
        chk("t6_busy", 32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_gap", 32'(pix_valid), 0);
        end
        @(negedge clk);
        chk("t6_first_cyc", 32'(cyc), 32'(m + 3));
        chk("t6_first_valid", 32'(pix_valid), 1);
        wait_done("t6_done_b", 100, at);
        chk("t6_done_cyc", 32'(at), 32'(m + 35));
        #1;
        chk("t6_hs", 32'(hs_cnt - h0), 2 * LPC);
        chk("t6_dones", 32'(done_cnt - d0), 2);
        chk("t6_q", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
